random_delay_counter: RTL and testbench

//  Upstream timing stage for the reaction-game controller. On arm, it waits a

---
 rtl/random_delay_counter_pkg.sv | 13 +
 rtl/random_delay_counter_lfsr.sv | 14 +
 rtl/random_delay_counter.sv | 83 ++++++++
 tb/tb_random_delay_counter.sv | 130 +++++++++++++
 4 files changed

// File: rtl/random_delay_counter_pkg.sv
// random_delay_counter_pkg: shared FSM encodings, LFSR taps and ms width for the reaction-game timing stage
package random_delay_counter_pkg;
  localparam int MS_W = 13;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1,
    S_DONE  = 2'd2
  } state_e;
  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return (v >> 1) ^ (v[0] ? LFSR_TAPS : 16'h0000);
  endfunction
endpackage

// File: rtl/random_delay_counter_lfsr.sv
// galois_lfsr16: free-running 16-bit right-shift Galois LFSR that self-recovers from the all-zero lock-up state
module galois_lfsr16
  import random_delay_counter_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        Clock,
  input  logic        Reset,
  output logic [15:0] q
);
  always_ff @(posedge Clock)
    if (Reset) q <= SEED;
    else       q <= (q == 16'h0000) ? SEED : lfsr_next(q);
endmodule

// File: rtl/random_delay_counter.sv
// random_delay_counter: arms on enable rising edge, waits MIN_DELAY_MS + random ms, pulses done; also emits a free ms tick
module random_delay_counter
  import random_delay_counter_pkg::*;
#(
  parameter int unsigned TICKS_PER_MS = 50000,
  parameter int unsigned MIN_DELAY_MS = 1000,
  parameter int unsigned RANGE_BITS   = 11,
  parameter logic [15:0] SEED         = 16'hACE1
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic            delayCounterEnable,
  output logic            delayCounterDone,
  output logic            msTick,
  output logic [MS_W-1:0] remainingMs,
  output logic            busy
);
  localparam int PW = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(TICKS_PER_MS - 1);
  localparam logic [15:0] RANGE_MASK = 16'((1 << RANGE_BITS) - 1);
  logic [15:0]     lfsr;
  state_e          state_q;
  logic [PW-1:0]   dp_q, tp_q;
  logic [MS_W-1:0] rem_q;
  logic            done_q, tick_q, en_prev_q;
  logic            arm;
  logic [MS_W-1:0] start_ms;
  galois_lfsr16 #(.SEED(SEED)) u_lfsr (
    .Clock (Clock),
    .Reset (Reset),
    .q     (lfsr)
  );
  assign arm      = delayCounterEnable & ~en_prev_q;
  assign start_ms = MS_W'(MIN_DELAY_MS) + MS_W'(lfsr & RANGE_MASK);
  always_ff @(posedge Clock)
    if (Reset) begin
      tp_q   <= '0;
      tick_q <= 1'b0;
    end else begin
      tick_q <= (tp_q == P_LAST);
      tp_q   <= (tp_q == P_LAST) ? '0 : tp_q + PW'(1);
    end
  // Abort is tested before expiry so a dropped enable never yields a done pulse.
  always_ff @(posedge Clock)
    if (Reset) begin
      state_q   <= S_IDLE;
      dp_q      <= '0;
      rem_q     <= '0;
      done_q    <= 1'b0;
      en_prev_q <= 1'b0;
    end else begin
      en_prev_q <= delayCounterEnable;
      done_q    <= 1'b0;
      case (state_q)
        S_IDLE:
          if (arm) begin
            state_q <= S_COUNT;
            rem_q   <= start_ms;
            dp_q    <= '0;
          end
        S_COUNT:
          if (!delayCounterEnable) begin
            state_q <= S_IDLE;
            rem_q   <= '0;
            dp_q    <= '0;
          end else if (dp_q == P_LAST) begin
            dp_q  <= '0;
            rem_q <= rem_q - MS_W'(1);
            if (rem_q == MS_W'(1)) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end
          end else begin
            dp_q <= dp_q + PW'(1);
          end
        default: state_q <= S_IDLE;
      endcase
    end
  assign delayCounterDone = done_q;
  assign msTick           = tick_q;
  assign remainingMs      = rem_q;
  assign busy             = (state_q == S_COUNT);
endmodule

// File: tb/tb_random_delay_counter.sv
// tb_random_delay_counter: directed checks of arm/latency/abort/reset/msTick with TICKS_PER_MS=4, MIN=3, RANGE_BITS=2
module tb_random_delay_counter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b0;
  logic        done, tick, busy;
  logic [12:0] rem;
  logic [15:0] m_lfsr;
  int          n;
  int          checks = 0;
  int          errors = 0;
  always #5 clk = ~clk;
  random_delay_counter #(
    .TICKS_PER_MS (4),
    .MIN_DELAY_MS (3),
    .RANGE_BITS   (2),
    .SEED         (16'hACE1)
  ) dut (
    .Clock              (clk),
    .Reset              (rst),
    .delayCounterEnable (en),
    .delayCounterDone   (done),
    .msTick             (tick),
    .remainingMs        (rem),
    .busy               (busy)
  );
  always @(posedge clk) begin
    m_lfsr <= (rst || m_lfsr == 16'h0) ? 16'hACE1 : ((m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0));
    n      <= rst ? 0 : n + 1;
  end
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  task automatic watch(input int len, output int first, output int pulses);
    first  = -1;
    pulses = 0;
    for (int i = 1; i <= len; i++) begin
      @(negedge clk);
      if (done) begin
        pulses++;
        if (first < 0) first = i;
      end
    end
  endtask
  function automatic logic [12:0] exp_ms(input logic [15:0] v);
    return 13'd3 + {11'd0, v[1:0]};
  endfunction
  initial begin
    int first, pulses;
    logic [12:0] e;
    repeat (3) @(negedge clk);
    check("rst lfsr", dut.u_lfsr.q, 16'hACE1);
    check("rst done", done, 0);
    check("rst rem", rem, 0);
    check("rst busy", busy, 0);
    check("rst tick", tick, 0);
    rst = 1'b0;
    @(negedge clk);
    check("lfsr step1", dut.u_lfsr.q, 16'hE270);
    @(negedge clk);
    check("lfsr step2", dut.u_lfsr.q, 16'h7138);
    check("idle done", done, 0);
    check("idle rem", rem, 0);
    repeat (18) @(negedge clk);
    check("lfsr step20", dut.u_lfsr.q, 16'h23B6);
    en = 1'b1;
    @(negedge clk);
    check("arm busy", busy, 1);
    check("arm rem", rem, 5);
    watch(40, first, pulses);
    check("latency 5ms", first, 20);
    check("held no repulse", pulses, 1);
    check("post done busy", busy, 0);
    check("post done rem", rem, 0);
    en = 1'b0;
    @(negedge clk);
    en = 1'b1;
    e = exp_ms(m_lfsr);
    @(negedge clk);
    check("rearm busy", busy, 1);
    check("rearm rem", rem, e);
    watch(4 * e + 8, first, pulses);
    check("rearm latency", first, 4 * e);
    check("rearm pulses", pulses, 1);
    en = 1'b0;
    @(negedge clk);
    en = 1'b1;
    e = exp_ms(m_lfsr);
    @(negedge clk);
    check("abort arm busy", busy, 1);
    repeat (4) @(negedge clk);
    check("first ms decrement", rem, e - 13'd1);
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    check("abort busy", busy, 0);
    check("abort rem", rem, 0);
    watch(40, first, pulses);
    check("abort no done", pulses, 0);
    en = 1'b1;
    e = exp_ms(m_lfsr);
    @(negedge clk);
    check("pre-reset busy", busy, 1);
    repeat (4 * e - 2) @(negedge clk);
    rst = 1'b1;
    en  = 1'b0;
    @(negedge clk);
    check("midreset done", done, 0);
    check("midreset rem", rem, 0);
    check("midreset busy", busy, 0);
    check("midreset tick", tick, 0);
    check("midreset lfsr", dut.u_lfsr.q, 16'hACE1);
    rst = 1'b0;
    watch(12, first, pulses);
    check("midreset no done", pulses, 0);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      check("mstick", tick, (n != 0 && n % 4 == 0) ? 1 : 0);
      if (i == 5) en = 1'b1;
      if (i == 22) en = 1'b0;
      if (i == 30) en = 1'b1;
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
